// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, flag bit positions,
// control FSM states and the ADD/SUB overflow helper.
package ex_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } ex_state_e;

  // Signed overflow from the operand and result sign bits. For SUB the second
  // operand's sign is inverted so the same "like signs in, other sign out" rule applies.
  function automatic logic add_sub_ovf(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = b_msb ^ is_sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/ex_stage_mc_mul_iter.sv
// Iterative shift-add multiplier. i_start loads the operands and sets the
// counter to WIDTH; each i_step adds the shifted multiplicand when the current
// multiplier bit is set. o_result is the accumulator including the step in
// progress, so it is the final product during the step where o_last is high.
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
  assign o_result   = w_acc_next;
  assign o_last     = (r_cnt == CW'(1));

  // Operand load, one shift-add step per enabled cycle, clear on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= CW'(WIDTH);
    end else if (i_step && (r_cnt != '0)) begin
      r_acc <= w_acc_next;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Registered execute stage: operand select, single-cycle ALU, iterative
// multiply, NVZ flag register and the EX/MEM result registers.
//
// Handshake: an op is taken on a rising edge where in_valid & in_ready & ~freeze
// & ~flush. in_ready depends on state alone (high in IDLE). Decode holds its op
// while not taken. out_valid is a one-cycle pulse per committed result, held
// (together with aluout) while freeze is asserted. busy mirrors the MUL state.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             alusrc,
  input  logic             memenable,
  input  logic             pcread,
  input  logic [1:0]       branch,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  output logic [WIDTH-1:0] aluout,
  output logic [2:0]       flag_out,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  ex_state_e        r_state;
  ex_state_e        w_state_next;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0] w_commit_res;
  logic [3:0]       w_commit_op;
  logic             w_commit_keep;
  logic             w_commit;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_keep_now;
  logic             r_keep_flag;
  logic             w_mul_start;
  logic             w_mul_step;
  logic             w_mul_last;
  logic             w_ovf;
  logic             w_z;
  logic [2:0]       r_flags;
  logic [2:0]       w_flags_next;
  logic [WIDTH-1:0] r_aluout;
  logic             r_out_valid;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == MUL);
  assign out_valid = r_out_valid;
  assign aluout    = r_aluout;
  assign flag_out  = r_flags;

  // Address mode forces a halfword-aligned base and a scaled offset.
  assign w_op1   = memenable ? {src1[WIDTH-1:1], 1'b0} : src1;
  assign w_op2   = alusrc ? (memenable ? (imm << 1) : imm) : src2;
  assign w_shamt = w_op2[SHW-1:0];

  assign w_accept   = in_valid & in_ready & ~freeze & ~flush;
  assign w_is_mul   = MUL_EN && (aluop == OP_MUL);
  assign w_keep_now = (|branch) | pcread;

  // Single-cycle ALU; unsupported opcodes (and MUL here) produce zero.
  always_comb begin
    w_alu_res = '0;
    case (aluop)
      OP_ADD:  w_alu_res = w_op1 + w_op2;
      OP_SUB:  w_alu_res = w_op1 - w_op2;
      OP_XOR:  w_alu_res = w_op1 ^ w_op2;
      OP_AND:  w_alu_res = w_op1 & w_op2;
      OP_OR:   w_alu_res = w_op1 | w_op2;
      OP_SLL:  w_alu_res = w_op1 << w_shamt;
      OP_SRA:  w_alu_res = WIDTH'($signed(w_op1) >>> w_shamt);
      OP_ROR:  w_alu_res = WIDTH'({w_op1, w_op1} >> w_shamt);
      OP_PASS: w_alu_res = w_op2;
      default: w_alu_res = '0;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (flush),
        .i_start  (w_mul_start),
        .i_step   (w_mul_step),
        .i_a      (w_op1),
        .i_b      (w_op2),
        .o_last   (w_mul_last),
        .o_result (w_mul_res)
      );
    end else begin : g_no_mul
      assign w_mul_last = 1'b0;
      assign w_mul_res  = '0;
    end
  endgenerate

  // Next-state logic: start a multiply on acceptance, step while unfrozen,
  // return to IDLE on the final step or on flush.
  always_comb begin
    w_state_next = r_state;
    w_mul_start  = 1'b0;
    w_mul_step   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_next = MUL;
          w_mul_start  = 1'b1;
        end
      end
      MUL: begin
        if (!freeze && !flush) begin
          w_mul_step = 1'b1;
          if (w_mul_last) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
  end

  // Select what commits this cycle and compute the flag update for it.
  always_comb begin
    w_commit      = (w_accept && !w_is_mul) || (w_mul_step && w_mul_last);
    w_commit_res  = busy ? w_mul_res : w_alu_res;
    w_commit_op   = busy ? OP_MUL : aluop;
    w_commit_keep = busy ? r_keep_flag : w_keep_now;
    w_ovf         = add_sub_ovf(w_op1[WIDTH-1], w_op2[WIDTH-1], w_alu_res[WIDTH-1],
                                (aluop == OP_SUB));
    w_z           = (w_commit_res == '0);
    w_flags_next  = r_flags;
    if (!w_commit_keep) begin
      case (w_commit_op)
        OP_ADD, OP_SUB: begin
          w_flags_next[FLAG_N] = w_commit_res[WIDTH-1];
          w_flags_next[FLAG_V] = w_ovf;
          w_flags_next[FLAG_Z] = w_z;
        end
        OP_XOR, OP_AND, OP_OR, OP_SLL, OP_SRA, OP_ROR: begin
          w_flags_next[FLAG_Z] = w_z;
        end
        OP_MUL: begin
          if (MUL_EN) w_flags_next[FLAG_Z] = w_z;
        end
        default: w_flags_next = r_flags;
      endcase
    end
  end

  // State register: flush overrides freeze, freeze holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (flush || !freeze) begin
      r_state <= w_state_next;
    end
  end

  // Flag-update suppression is latched with the multiply operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keep_flag <= 1'b0;
    end else if (w_mul_start) begin
      r_keep_flag <= w_keep_now;
    end
  end

  // Result and flag registers; out_valid pulses on commit, holds under freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluout    <= '0;
      r_out_valid <= 1'b0;
      r_flags     <= 3'b000;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (!freeze) begin
      r_out_valid <= w_commit;
      if (w_commit) begin
        r_aluout <= w_commit_res;
        r_flags  <= w_flags_next;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc at WIDTH=16 with the multiplier enabled.
module tb_ex_stage_mc;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         freeze;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         alusrc;
  logic         memenable;
  logic         pcread;
  logic [1:0]   branch;
  logic [3:0]   aluop;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [W-1:0] imm;
  logic         out_valid;
  logic [W-1:0] aluout;
  logic [2:0]   flag_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ex_stage_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alusrc    (alusrc),
    .memenable (memenable),
    .pcread    (pcread),
    .branch    (branch),
    .aluop     (aluop),
    .src1      (src1),
    .src2      (src2),
    .imm       (imm),
    .out_valid (out_valid),
    .aluout    (aluout),
    .flag_out  (flag_out),
    .busy      (busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    in_valid  = 1'b0;
    alusrc    = 1'b0;
    memenable = 1'b0;
    pcread    = 1'b0;
    branch    = 2'b00;
    aluop     = 4'd0;
    src1      = '0;
    src2      = '0;
    imm       = '0;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] im, input logic asrc, input logic mem);
    in_valid  = 1'b1;
    aluop     = op;
    src1      = a;
    src2      = b;
    imm       = im;
    alusrc    = asrc;
    memenable = mem;
    pcread    = 1'b0;
    branch    = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    checks++; if (aluout !== 16'h0000) begin errors++; $display("FAIL reset_aluout got %h exp 0000", aluout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (flag_out !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", flag_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_add_overflow;
    drive_op(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_idle();
    checks++; if (aluout !== 16'h8000) begin errors++; $display("FAIL add_ovf_res got %h exp 8000", aluout); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_ovf_valid got %b exp 1", out_valid); end
    checks++; if (flag_out !== 3'b110) begin errors++; $display("FAIL add_ovf_flags got %b exp 110", flag_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_ovf_pulse got %b exp 0", out_valid); end
    checks++; if (aluout !== 16'h8000) begin errors++; $display("FAIL add_ovf_hold got %h exp 8000", aluout); end
  endtask

  task automatic test_mem_addr;
    drive_op(4'd0, 16'h1235, 16'h0000, 16'h0003, 1'b1, 1'b1);
    tick();
    drive_idle();
    checks++; if (aluout !== 16'h123A) begin errors++; $display("FAIL mem_addr_res got %h exp 123a", aluout); end
    checks++; if (flag_out !== 3'b000) begin errors++; $display("FAIL mem_addr_flags got %b exp 000", flag_out); end
  endtask

  task automatic test_alu_ops;
    logic [3:0] t_op [0:10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd9, 4'd12, 4'd1};
    logic [W-1:0] t_a [0:10] = '{16'h0005, 16'h00F0, 16'hF0F0, 16'h1200, 16'h0001, 16'h8000,
                                 16'h0001, 16'h1234, 16'h5555, 16'h1234, 16'h8000};
    logic [W-1:0] t_b [0:10] = '{16'h0007, 16'h00F0, 16'h0F0F, 16'h0034, 16'h0014, 16'h0004,
                                 16'h0001, 16'h0000, 16'hABCD, 16'h1234, 16'h0001};
    logic [W-1:0] t_exp [0:10] = '{16'hFFFE, 16'h0000, 16'h0000, 16'h1234, 16'h0010, 16'hF800,
                                   16'h8000, 16'h1234, 16'hABCD, 16'h0000, 16'h7FFF};
    logic [2:0] t_flg [0:10] = '{3'b100, 3'b101, 3'b101, 3'b100, 3'b100, 3'b100,
                                 3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
    for (int i = 0; i < 11; i++) begin
      drive_op(t_op[i], t_a[i], t_b[i], 16'h0000, 1'b0, 1'b0);
      tick();
      checks++; if (aluout !== t_exp[i]) begin errors++; $display("FAIL alu_op%0d_res got %h exp %h", i, aluout, t_exp[i]); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_op%0d_valid got %b exp 1", i, out_valid); end
      checks++; if (flag_out !== t_flg[i]) begin errors++; $display("FAIL alu_op%0d_flags got %b exp %b", i, flag_out, t_flg[i]); end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_mul_basic;
    int lat;
    int low;
    lat = 0;
    low = 0;
    drive_op(4'd8, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready got %b exp 0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy got %b exp 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_no_early_valid got %b exp 0", out_valid); end
    if (in_ready === 1'b0) low++;
    // Decode now presents a different op and keeps it valid; it must wait.
    drive_op(4'd0, 16'h0002, 16'h0002, 16'h0000, 1'b0, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (in_ready === 1'b0) low++;
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL mul_latency got %0d exp 16", lat); end
    checks++; if (low !== 16) begin errors++; $display("FAIL mul_ready_low got %0d exp 16", low); end
    checks++; if (aluout !== 16'h000F) begin errors++; $display("FAIL mul_res got %h exp 000f", aluout); end
    checks++; if (flag_out !== 3'b010) begin errors++; $display("FAIL mul_flags got %b exp 010", flag_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_ready_back got %b exp 1", in_ready); end
    tick();
    drive_idle();
    checks++; if (aluout !== 16'h0004) begin errors++; $display("FAIL mul_next_op got %h exp 0004", aluout); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_next_valid got %b exp 1", out_valid); end
    tick();
  endtask

  task automatic test_flags_branch;
    drive_op(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_op(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0);
    branch = 2'b01;
    tick();
    checks++; if (aluout !== 16'h0000) begin errors++; $display("FAIL branch_res got %h exp 0000", aluout); end
    checks++; if (flag_out !== 3'b110) begin errors++; $display("FAIL branch_keep got %b exp 110", flag_out); end
    drive_op(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0);
    pcread = 1'b1;
    tick();
    checks++; if (flag_out !== 3'b110) begin errors++; $display("FAIL pcread_keep got %b exp 110", flag_out); end
    drive_op(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_idle();
    checks++; if (flag_out !== 3'b001) begin errors++; $display("FAIL sub_zero_flags got %b exp 001", flag_out); end
    tick();
  endtask

  task automatic test_freeze_hold;
    drive_op(4'd0, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0);
    tick();
    freeze = 1'b1;
    drive_op(4'd0, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL freeze_valid_hold got %b exp 1", out_valid); end
    checks++; if (aluout !== 16'h0003) begin errors++; $display("FAIL freeze_res_hold got %h exp 0003", aluout); end
    checks++; if (flag_out !== 3'b000) begin errors++; $display("FAIL freeze_flags got %b exp 000", flag_out); end
    drive_idle();
    freeze = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unfreeze_valid got %b exp 0", out_valid); end
    checks++; if (aluout !== 16'h0003) begin errors++; $display("FAIL unfreeze_res got %h exp 0003", aluout); end
  endtask

  task automatic test_mul_freeze;
    int lat;
    lat = 0;
    drive_op(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_op(4'd8, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_idle();
    for (int c = 1; c <= 40; c++) begin
      freeze = (c >= 6 && c <= 8);
      tick();
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    freeze = 1'b0;
    checks++; if (lat !== 19) begin errors++; $display("FAIL mul_freeze_latency got %0d exp 19", lat); end
    checks++; if (aluout !== 16'h0000) begin errors++; $display("FAIL mul_freeze_res got %h exp 0000", aluout); end
    checks++; if (flag_out !== 3'b111) begin errors++; $display("FAIL mul_freeze_flags got %b exp 111", flag_out); end
    tick();
  endtask

  task automatic test_mul_flush;
    int seen;
    seen = 0;
    drive_op(4'd8, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 4; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_idle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
    for (int c = 0; c < 20; c++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_valid got %0d exp 0", seen); end
    checks++; if (aluout !== 16'h0000) begin errors++; $display("FAIL flush_res got %h exp 0000", aluout); end
    checks++; if (flag_out !== 3'b111) begin errors++; $display("FAIL flush_flags got %b exp 111", flag_out); end
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    seen = 0;
    drive_op(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_op(4'd8, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_idle();
    for (int c = 1; c <= 7; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (aluout !== 16'h0000) begin errors++; $display("FAIL rst_mul_res got %h exp 0000", aluout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mul_valid got %b exp 0", out_valid); end
    checks++; if (flag_out !== 3'b000) begin errors++; $display("FAIL rst_mul_flags got %b exp 000", flag_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mul_ready got %b exp 1", in_ready); end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mul_abandon got %0d exp 0", seen); end
    drive_op(4'd2, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b0);
    tick();
    drive_idle();
    checks++; if (aluout !== 16'h0000) begin errors++; $display("FAIL post_rst_xor_res got %h exp 0000", aluout); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_xor_valid got %b exp 1", out_valid); end
    checks++; if (flag_out !== 3'b001) begin errors++; $display("FAIL post_rst_xor_flags got %b exp 001", flag_out); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_add_overflow();
    test_mem_addr();
    test_alu_ops();
    test_mul_basic();
    test_flags_branch();
    test_freeze_hold();
    test_mul_freeze();
    test_mul_flush();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
